// File: rtl/csr_mwrite_file_pkg.sv
// csr_pkg: shared CSR addresses, op encoding, bit indices, writable masks and cause codes
package csr_pkg;
  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11} csr_op_e;
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MTIP_BIT = 7;
  localparam int MEIP_BIT = 11;
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_MPP   = 32'h0000_1800;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0880;
  localparam logic [31:0] MTVEC_WMASK   = 32'hFFFF_FFFC;
  localparam logic [31:0] MEPC_WMASK    = 32'hFFFF_FFFC;
  localparam logic [31:0] FULL_WMASK    = 32'hFFFF_FFFF;
  localparam logic [31:0] CAUSE_MTI     = 32'h8000_0007;
  localparam logic [31:0] CAUSE_MEI     = 32'h8000_000B;
endpackage

// File: rtl/csr_mwrite_file_if.sv
// csr_mwrite_file_if: CSR access bus between execute stage and the CSR file
interface csr_mwrite_file_if;
  logic        csr_valid;
  logic [1:0]  csr_op;
  logic        csr_wr_en;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  modport master (output csr_valid, csr_op, csr_wr_en, csr_addr, csr_wdata, input csr_rdata, csr_illegal);
  modport slave (input csr_valid, csr_op, csr_wr_en, csr_addr, csr_wdata, output csr_rdata, csr_illegal);
endinterface

// File: rtl/csr_mwrite_file_rmw.sv
// csr_rmw: CSRRW/CSRRS/CSRRC new-value computation, masked to the writable bits of the target
module csr_rmw
  import csr_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] old,
  input  logic [31:0] wdata,
  input  logic [31:0] mask,
  output logic [31:0] new_val
);
  csr_op_e o;
  assign o = csr_op_e'(op);
  always_comb new_val = (o == OP_RW ? wdata : o == OP_RS ? old | wdata : o == OP_RC ? old & ~wdata : old) & mask;
endmodule

// File: rtl/csr_mwrite_file.sv
// csr_mwrite_file: machine-mode CSR read-modify-write, trap entry/MRET sequencing, registered irq request.
// Optional mscratch (0x340) enabled by CSR_MSCRATCH_EN.
module csr_mwrite_file
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter int          XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst,
  csr_mwrite_file_if.slave bus,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_valid,
  input  logic            irq_timer,
  input  logic            irq_ext,
  output logic            irq_req,
  output logic [XLEN-1:0] irq_cause,
  output logic [XLEN-1:0] mtvec_out,
  output logic [XLEN-1:0] mepc_out,
  output logic            mie_bit_out
);
  logic [31:0] mstatus_q, mie_q, mtvec_q, mepc_q, mcause_q, mtval_q, mip_q;
  logic [31:0] mstatus_d, mie_d, mtvec_d, mepc_d, mcause_d, mtval_d, mip_d, cause_d;
  logic [31:0] old, mask, wval;
  logic        known, illegal, wr, irq_d;
`ifdef CSR_MSCRATCH_EN
  logic [31:0] mscratch_q, mscratch_d;
`endif
  always_comb begin
    known = 1'b1;
    old = '0;
    mask = '0;
    case (bus.csr_addr)
      ADDR_MSTATUS: begin old = mstatus_q | MSTATUS_MPP; mask = MSTATUS_WMASK; end
      ADDR_MIE:     begin old = mie_q; mask = MIE_WMASK; end
      ADDR_MTVEC:   begin old = mtvec_q; mask = MTVEC_WMASK; end
      ADDR_MEPC:    begin old = mepc_q; mask = MEPC_WMASK; end
      ADDR_MCAUSE:  begin old = mcause_q; mask = FULL_WMASK; end
      ADDR_MTVAL:   begin old = mtval_q; mask = FULL_WMASK; end
      ADDR_MIP:     old = mip_q;
`ifdef CSR_MSCRATCH_EN
      ADDR_MSCRATCH: begin old = mscratch_q; mask = FULL_WMASK; end
`endif
      default:      known = 1'b0;
    endcase
  end
  assign illegal = bus.csr_valid & (!known | bus.csr_op == OP_NOP | (bus.csr_addr == ADDR_MIP & bus.csr_wr_en));
  assign bus.csr_illegal = illegal;
  assign bus.csr_rdata = illegal ? '0 : old;
  // Trap and MRET each drop a same-cycle CSR write entirely, whatever CSR it targets
  assign wr = bus.csr_valid & bus.csr_op != OP_NOP & bus.csr_wr_en & !illegal & !trap_valid & !mret_valid;
  csr_rmw u_rmw (.op(bus.csr_op), .old(old), .wdata(bus.csr_wdata), .mask(mask), .new_val(wval));
  always_comb begin
    mstatus_d = trap_valid ? 32'(mstatus_q[MIE_BIT]) << MPIE_BIT
              : mret_valid ? (32'(mstatus_q[MPIE_BIT]) << MIE_BIT) | (32'd1 << MPIE_BIT)
              : wr && bus.csr_addr == ADDR_MSTATUS ? wval : mstatus_q;
    mie_d    = wr && bus.csr_addr == ADDR_MIE ? wval : mie_q;
    mtvec_d  = wr && bus.csr_addr == ADDR_MTVEC ? wval : mtvec_q;
    mepc_d   = trap_valid ? trap_pc & MEPC_WMASK : wr && bus.csr_addr == ADDR_MEPC ? wval : mepc_q;
    mcause_d = trap_valid ? trap_cause : wr && bus.csr_addr == ADDR_MCAUSE ? wval : mcause_q;
    mtval_d  = trap_valid ? trap_tval : wr && bus.csr_addr == ADDR_MTVAL ? wval : mtval_q;
`ifdef CSR_MSCRATCH_EN
    mscratch_d = wr && bus.csr_addr == ADDR_MSCRATCH ? wval : mscratch_q;
`endif
    mip_d = (32'(irq_ext) << MEIP_BIT) | (32'(irq_timer) << MTIP_BIT);
    // Registered mip against updated enables: two cycles from pins, same-edge drop on trap entry
    irq_d = mstatus_d[MIE_BIT] & |(mip_q & mie_d);
    cause_d = mip_q[MEIP_BIT] & mie_d[MEIP_BIT] ? CAUSE_MEI : mip_q[MTIP_BIT] & mie_d[MTIP_BIT] ? CAUSE_MTI : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_q <= '0;
      mie_q <= '0;
      mtvec_q <= MTVEC_RST & MTVEC_WMASK;
      mepc_q <= '0;
      mcause_q <= '0;
      mtval_q <= '0;
      mip_q <= '0;
      irq_req <= 1'b0;
      irq_cause <= '0;
    end else begin
      mstatus_q <= mstatus_d;
      mie_q <= mie_d;
      mtvec_q <= mtvec_d;
      mepc_q <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q <= mtval_d;
      mip_q <= mip_d;
      irq_req <= irq_d;
      irq_cause <= cause_d;
    end
  end
`ifdef CSR_MSCRATCH_EN
  always_ff @(posedge clk or posedge rst) mscratch_q <= rst ? '0 : mscratch_d;
`endif
  assign mtvec_out = mtvec_q;
  assign mepc_out = mepc_q;
  assign mie_bit_out = mstatus_q[MIE_BIT];
endmodule
